// File: rtl/fxp_pkg.sv
// Shared fixed-point format constants, types and multiplier FSM states.
// Default format is signed Q16.16.
package fxp_pkg;

  localparam int FXP_N    = 32;
  localparam int FXP_FRAC = 16;

  typedef logic signed [FXP_N-1:0] fxp_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ROUND,
    DONE
  } fxp_mul_state_e;

  localparam fxp_t FXP_MAX = {1'b0, {(FXP_N-1){1'b1}}};
  localparam fxp_t FXP_MIN = {1'b1, {(FXP_N-1){1'b0}}};

endpackage

// File: rtl/fxp_mul_seq_if.sv
// Operand/result valid-ready bundle for the sequential multiplier.
// master drives operands and out_ready; slave is the multiplier.
interface fxp_mul_seq_if #(
  parameter int N = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, ovf
  );

endinterface

// File: rtl/fxp_round_sat.sv
// Rounds a 2N-bit product magnitude to Q format, range-checks, applies sign.
// FXP_MUL_SAT_EN selects saturation on overflow; otherwise the result wraps.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int N    = FXP_N,
  parameter int FRAC = FXP_FRAC
) (
  input  logic [2*N-1:0] i_mag,
  input  logic           i_sign,
  output logic [N-1:0]   o_result,
  output logic           o_ovf
);

  localparam int W = 2*N + 1;
  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W-1:0] HALF  = ONE << (FRAC-1);
  localparam logic [W-1:0] P_LIM = (ONE << (N-1)) - ONE;
  localparam logic [W-1:0] N_LIM = ONE << (N-1);
  localparam logic [N-1:0] SMAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SMIN  = {1'b1, {(N-1){1'b0}}};

  logic [W-1:0] w_m;
  logic [N-1:0] w_val;
  logic         w_ovf;

  // Rounding the magnitude gives half-away-from-zero after the sign is applied
  assign w_m   = ({1'b0, i_mag} + HALF) >> FRAC;
  assign w_ovf = i_sign ? (w_m > N_LIM) : (w_m > P_LIM);
  assign w_val = i_sign ? (N'(0) - w_m[N-1:0]) : w_m[N-1:0];

  assign o_ovf = w_ovf;

`ifdef FXP_MUL_SAT_EN
  assign o_result = w_ovf ? (i_sign ? SMIN : SMAX) : w_val;
`else
  assign o_result = w_val;
`endif

endmodule

// File: rtl/fxp_mul_seq.sv
// Sequential signed fixed-point multiplier, one multiplier bit per cycle.
// Optional macro FXP_MUL_SAT_EN saturates overflowed results.
module fxp_mul_seq
  import fxp_pkg::*;
#(
  parameter int N    = FXP_N,
  parameter int FRAC = FXP_FRAC
) (
  input  logic         clk,
  input  logic         rst,
  fxp_mul_seq_if.slave bus
);

  localparam int CW = $clog2(N) + 1;

  fxp_mul_state_e r_state;
  logic [N-1:0]   r_mcand;
  logic [N-1:0]   r_mplier;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_sign;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [N-1:0]   r_result;
  logic           r_ovf;

  logic [N-1:0]   w_a_mag;
  logic [N-1:0]   w_b_mag;
  logic [N-1:0]   w_addend;
  logic [N:0]     w_sum;
  logic [N-1:0]   w_rnd_result;
  logic           w_rnd_ovf;

  // Unsigned magnitudes; the most negative value maps exactly to 2^(N-1)
  assign w_a_mag  = bus.a[N-1] ? (N'(0) - bus.a) : bus.a;
  assign w_b_mag  = bus.b[N-1] ? (N'(0) - bus.b) : bus.b;
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_acc[2*N-1:N]} + {1'b0, w_addend};

  fxp_round_sat #(
    .N    (N),
    .FRAC (FRAC)
  ) u_round (
    .i_mag    (r_acc),
    .i_sign   (r_sign),
    .o_result (w_rnd_result),
    .o_ovf    (w_rnd_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mcand    <= w_a_mag;
            r_mplier   <= w_b_mag;
            r_sign     <= bus.a[N-1] ^ bus.b[N-1];
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          // Carry of the N+1-bit sum shifts into the top of acc
          r_acc    <= {w_sum, r_acc[N-1:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(N-1)) begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_result    <= w_rnd_result;
          r_ovf       <= w_rnd_ovf;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_fxp_mul_seq.sv
// Directed testbench for fxp_mul_seq (Q16.16).
// Expected values are hand-computed products of the operands.
module tb_fxp_mul_seq;
  import fxp_pkg::*;

  localparam int N = 32;
  localparam int LAT = N + 2;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fxp_mul_seq_if #(.N(N)) bus ();

  fxp_mul_seq #(
    .N    (N),
    .FRAC (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation with out_ready held high; lat counts edges
  // from the acceptance edge (inclusive) to out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ov,
                        output int lat);
    int t;
    bus.out_ready = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      tick();
      t++;
    end
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL run_op timeout a=%h b=%h: out_valid=0 required 1", a, b);
    end
    res = bus.result;
    ov  = bus.ovf;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.result !== 32'h0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b res=%h ovf=%b required 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.ovf);
    end
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required IDLE", dut.r_state);
    end
  endtask

  task automatic test_basic();
    logic [31:0] va[6] = '{32'h00018000, 32'hFFFE8000, 32'h00018000,
                           32'hFFFF0000, 32'h00000000, 32'h00000000};
    logic [31:0] vb[6] = '{32'h00020000, 32'h00020000, 32'hFFFE0000,
                           32'hFFFF0000, 32'hFFFF0000, 32'h00000000};
    logic [31:0] vr[6] = '{32'h00030000, 32'hFFFD0000, 32'hFFFD0000,
                           32'h00010000, 32'h00000000, 32'h00000000};
    logic [31:0] res;
    logic        ov;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], res, ov, lat);
      checks++;
      if (res !== vr[i] || ov !== 1'b0) begin
        errors++;
        $display("FAIL basic_%0d: result=%h ovf=%b required %h 0",
                 i, res, ov, vr[i]);
      end
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("FAIL latency_%0d: got %0d required %0d", i, lat, LAT);
      end
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: vld=%b rdy=%b required 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] va[3] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000001};
    logic [31:0] vb[3] = '{32'h00008000, 32'h00008000, 32'h00004000};
    logic [31:0] vr[3] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    logic [31:0] res;
    logic        ov;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], res, ov, lat);
      checks++;
      if (res !== vr[i] || ov !== 1'b0) begin
        errors++;
        $display("FAIL round_%0d: result=%h ovf=%b required %h 0",
                 i, res, ov, vr[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] va[3] = '{32'h80000000, 32'h7FFF0000, 32'h80000000};
    logic [31:0] vb[3] = '{32'h00010000, 32'h00020000, 32'hFFFF0000};
    logic        vo[3] = '{1'b0, 1'b1, 1'b1};
`ifdef FXP_MUL_SAT_EN
    logic [31:0] vr[3] = '{32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
`else
    logic [31:0] vr[3] = '{32'h80000000, 32'hFFFE0000, 32'h80000000};
`endif
    logic [31:0] res;
    logic        ov;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], res, ov, lat);
      checks++;
      if (res !== vr[i] || ov !== vo[i]) begin
        errors++;
        $display("FAIL ovf_%0d: result=%h ovf=%b required %h %b",
                 i, res, ov, vr[i], vo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    bus.out_ready = 1'b0;
    bus.a = 32'h00018000;
    bus.b = 32'h00020000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_accept: in_ready=%b required 0", bus.in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 32'h7FFF0000;
      bus.b = 32'h7FFF0000;
      tick();
    end
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 100) begin
      tick();
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'h00030000 ||
          bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hs_hold_%0d: vld=%b res=%h rdy=%b required 1 00030000 0",
                 i, bus.out_valid, bus.result, bus.in_ready);
      end
    end
    bus.a = 32'hFFFE8000;
    bus.b = 32'h00020000;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hs_release: vld=%b rdy=%b required 0 1",
               bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_b2b_accept: in_ready=%b required 0", bus.in_ready);
    end
    t = 0;
    while (!bus.out_valid && t < 100) begin
      tick();
      t++;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'hFFFD0000 ||
        bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL hs_b2b_result: vld=%b res=%h ovf=%b required 1 FFFD0000 0",
               bus.out_valid, bus.result, bus.ovf);
    end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic        ov;
    int          lat;
    bool_stale: begin end
    bus.out_ready = 1'b1;
    bus.a = 32'h7FFF0000;
    bus.b = 32'h00020000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (dut.r_state !== IDLE || bus.in_ready !== 1'b1 ||
        bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: st=%0d rdy=%b vld=%b res=%h ovf=%b required IDLE 1 0 0 0",
               dut.r_state, bus.in_ready, bus.out_valid, bus.result, bus.ovf);
    end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) lat++;
    end
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL mid_reset_stale: out_valid high %0d cycles required 0", lat);
    end
    run_op(32'h00018000, 32'h00020000, res, ov, lat);
    checks++;
    if (res !== 32'h00030000 || ov !== 1'b0 || lat != LAT) begin
      errors++;
      $display("FAIL mid_reset_fresh: result=%h ovf=%b lat=%0d required 00030000 0 %0d",
               res, ov, lat, LAT);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
